// File: rtl/pipe_tx_blk_buf_if.sv
// Producer/host-side bundle for the block transmit buffer.
interface pipe_tx_blk_buf_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2048,
    parameter int CNT_W  = 16
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic              rd_ready;
    logic [DATA_W-1:0] dout;
    logic [LVL_W-1:0]  level;
    logic              in_block;
    logic [CNT_W-1:0]  ovf_cnt;
    logic              rd_err;

    modport master (
        output flush, wr_en, din, rd_en,
        input  rd_ready, dout, level, in_block, ovf_cnt, rd_err
    );

    modport slave (
        input  flush, wr_en, din, rd_en,
        output rd_ready, dout, level, in_block, ovf_cnt, rd_err
    );
endinterface

// File: rtl/pipe_tx_blk_buf.sv
// Show-ahead circular buffer handing data to the host pipe in
// fixed-length blocks, with overflow policy, flush and status.
module pipe_tx_blk_buf #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 2048,
    parameter int BLK_LEN  = 1024,
    parameter int OVF_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_tx_blk_buf_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int BW    = $clog2(BLK_LEN + 1);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_READ
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     blk_cnt_q, blk_cnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  ovf_q, ovf_d;
    logic              rd_err_q, rd_err_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic rdy;
    logic full;
    logic pop;
    logic push;
    logic ovf_ev;
    logic discard;

    assign rdy  = (state_q == ST_IDLE) &&
                  (level_q >= LVL_W'(BLK_LEN));
    assign full = (level_q == LVL_W'(DEPTH));

    assign pop = !bus.flush && bus.rd_en &&
                 (level_q != '0) &&
                 ((state_q == ST_READ) || rdy);

    assign ovf_ev = !bus.flush && bus.wr_en &&
                    full && !pop;

    // Dropping the oldest word mid-block would corrupt the block.
    assign discard = ovf_ev && (OVF_MODE == 1) &&
                     (state_q == ST_IDLE);

    assign push = !bus.flush && bus.wr_en &&
                  (!full || pop || discard);

    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        rd_err_d  = rd_err_q;
        dout_d    = dout_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop || discard) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push && !discard, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (ovf_ev && (ovf_q != '1)) begin
            ovf_d = ovf_q + CNT_W'(1);
        end

        if (!bus.flush && bus.rd_en && !pop) begin
            rd_err_d = 1'b1;
        end

        if (pop) begin
            if (state_q == ST_IDLE) begin
                if (BLK_LEN > 1) begin
                    state_d   = ST_READ;
                    blk_cnt_d = BW'(1);
                end
            end else if (blk_cnt_q == BW'(BLK_LEN - 1)) begin
                state_d   = ST_IDLE;
                blk_cnt_d = '0;
            end else begin
                blk_cnt_d = blk_cnt_q + BW'(1);
            end
        end

        if (bus.flush) begin
            state_d   = ST_IDLE;
            blk_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
        end

        // Forward din when the new head is the word written now.
        if (level_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                dout_d = bus.din;
            end else begin
                dout_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            blk_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= '0;
            rd_err_q  <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            rd_err_q  <= rd_err_d;
            dout_q    <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.rd_ready = rdy;
    assign bus.dout     = dout_q;
    assign bus.level    = level_q;
    assign bus.in_block = (state_q == ST_READ);
    assign bus.ovf_cnt  = ovf_q;
    assign bus.rd_err   = rd_err_q;
endmodule

// File: tb/tb_pipe_tx_blk_buf.sv
// Directed bench: drop-mode and discard-mode buffers driven in lockstep.
module tb_pipe_tx_blk_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipe_tx_blk_buf_if #(.DATA_W(16), .DEPTH(16), .CNT_W(4)) b0 ();
    pipe_tx_blk_buf_if #(.DATA_W(16), .DEPTH(16), .CNT_W(4)) b1 ();

    pipe_tx_blk_buf #(
        .DATA_W(16), .DEPTH(16), .BLK_LEN(4), .OVF_MODE(0), .CNT_W(4)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    pipe_tx_blk_buf #(
        .DATA_W(16), .DEPTH(16), .BLK_LEN(4), .OVF_MODE(1), .CNT_W(4)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    typedef struct {
        logic        fl;
        logic        we;
        logic [15:0] d;
        logic        re;
        logic        rdy;
        logic [15:0] dout;
        int          lvl;
        logic        inb;
        logic        err;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic fl, input logic we, input logic [15:0] d,
        input logic re, input logic rdy, input logic [15:0] dout,
        input int lvl, input logic inb, input logic err
    );
        vec_t v;
        v.fl = fl; v.we = we; v.d = d; v.re = re;
        v.rdy = rdy; v.dout = dout; v.lvl = lvl;
        v.inb = inb; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drv(
        input logic fl, input logic we,
        input logic [15:0] d, input logic re
    );
        b0.flush = fl; b0.wr_en = we; b0.din = d; b0.rd_en = re;
        b1.flush = fl; b1.wr_en = we; b1.din = d; b1.rd_en = re;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " lvl0"}, int'(b0.level), 0);
        chk({tag, " dout0"}, int'(b0.dout), 0);
        chk({tag, " rdy0"}, int'(b0.rd_ready), 0);
        chk({tag, " inb0"}, int'(b0.in_block), 0);
        chk({tag, " ovf0"}, int'(b0.ovf_cnt), 0);
        chk({tag, " err0"}, int'(b0.rd_err), 0);
        chk({tag, " lvl1"}, int'(b1.level), 0);
        chk({tag, " dout1"}, int'(b1.dout), 0);
        chk({tag, " inb1"}, int'(b1.in_block), 0);
        chk({tag, " ovf1"}, int'(b1.ovf_cnt), 0);
        chk({tag, " err1"}, int'(b1.rd_err), 0);
    endtask

    initial begin
        // block of 1..4 read back-to-back
        tv.push_back(mk(0, 1, 16'h0001, 0, 0, 16'h0001, 1, 0, 0));
        tv.push_back(mk(0, 1, 16'h0002, 0, 0, 16'h0001, 2, 0, 0));
        tv.push_back(mk(0, 1, 16'h0003, 0, 0, 16'h0001, 3, 0, 0));
        tv.push_back(mk(0, 1, 16'h0004, 0, 1, 16'h0001, 4, 0, 0));
        tv.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0002, 3, 1, 0));
        tv.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0003, 2, 1, 0));
        tv.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0004, 1, 1, 0));
        tv.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0004, 0, 0, 0));
        // six words, block read with gaps 1,0,1,1,0,1
        tv.push_back(mk(0, 1, 16'h0011, 0, 0, 16'h0011, 1, 0, 0));
        tv.push_back(mk(0, 1, 16'h0012, 0, 0, 16'h0011, 2, 0, 0));
        tv.push_back(mk(0, 1, 16'h0013, 0, 0, 16'h0011, 3, 0, 0));
        tv.push_back(mk(0, 1, 16'h0014, 0, 1, 16'h0011, 4, 0, 0));
        tv.push_back(mk(0, 1, 16'h0015, 0, 1, 16'h0011, 5, 0, 0));
        tv.push_back(mk(0, 1, 16'h0016, 0, 1, 16'h0011, 6, 0, 0));
        tv.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0012, 5, 1, 0));
        tv.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0012, 5, 1, 0));
        tv.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0013, 4, 1, 0));
        tv.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0014, 3, 1, 0));
        tv.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0014, 3, 1, 0));
        tv.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0015, 2, 0, 0));
        // illegal read in IDLE with level 3, then flush
        tv.push_back(mk(0, 1, 16'h0017, 0, 0, 16'h0015, 3, 0, 0));
        tv.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0015, 3, 0, 1));
        tv.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0015, 3, 0, 1));
        tv.push_back(mk(1, 1, 16'h0055, 1, 0, 16'h0015, 0, 0, 1));
        tv.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0015, 0, 0, 1));

        b0.flush = 0; b0.wr_en = 0; b0.din = '0; b0.rd_en = 0;
        b1.flush = 0; b1.wr_en = 0; b1.din = '0; b1.rd_en = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drv(tv[i].fl, tv[i].we, tv[i].d, tv[i].re);
            chk($sformatf("v%0d rdy", i), int'(b0.rd_ready), int'(tv[i].rdy));
            chk($sformatf("v%0d dout", i), int'(b0.dout), int'(tv[i].dout));
            chk($sformatf("v%0d lvl", i), int'(b0.level), tv[i].lvl);
            chk($sformatf("v%0d inb", i), int'(b0.in_block), int'(tv[i].inb));
            chk($sformatf("v%0d err", i), int'(b0.rd_err), int'(tv[i].err));
            chk($sformatf("v%0d dout1", i), int'(b1.dout), int'(tv[i].dout));
        end

        // overflow in IDLE: drop vs discard-oldest
        for (int i = 1; i <= 18; i++) drv(0, 1, 16'(i), 0);
        chk("ovf0 lvl", int'(b0.level), 16);
        chk("ovf0 cnt", int'(b0.ovf_cnt), 2);
        chk("ovf0 dout", int'(b0.dout), 1);
        chk("ovf1 lvl", int'(b1.level), 16);
        chk("ovf1 cnt", int'(b1.ovf_cnt), 2);
        chk("ovf1 dout", int'(b1.dout), 3);
        chk("ovf rdy", int'(b0.rd_ready), 1);

        // overflow during a block: dropped in both modes
        drv(0, 0, 16'h0000, 1);
        chk("blk p1 dout0", int'(b0.dout), 2);
        chk("blk p1 dout1", int'(b1.dout), 4);
        chk("blk p1 inb", int'(b1.in_block), 1);
        chk("blk p1 lvl", int'(b0.level), 15);
        drv(0, 1, 16'h00a0, 0);
        chk("blk refill lvl", int'(b1.level), 16);
        drv(0, 1, 16'h00a1, 0);
        chk("blk drop cnt0", int'(b0.ovf_cnt), 3);
        chk("blk drop cnt1", int'(b1.ovf_cnt), 3);
        chk("blk drop dout1", int'(b1.dout), 4);
        chk("blk drop lvl", int'(b1.level), 16);
        drv(0, 1, 16'h00a2, 1);
        chk("pushpop lvl", int'(b0.level), 16);
        chk("pushpop cnt", int'(b1.ovf_cnt), 3);
        chk("pushpop dout0", int'(b0.dout), 3);
        chk("pushpop dout1", int'(b1.dout), 5);
        drv(0, 0, 16'h0000, 1);
        chk("blk p3 dout0", int'(b0.dout), 4);
        chk("blk p3 dout1", int'(b1.dout), 6);
        drv(0, 0, 16'h0000, 1);
        chk("blk p4 dout0", int'(b0.dout), 5);
        chk("blk p4 dout1", int'(b1.dout), 7);
        chk("blk p4 lvl", int'(b0.level), 14);
        chk("blk p4 inb", int'(b0.in_block), 0);
        chk("blk p4 rdy", int'(b1.rd_ready), 1);

        // flush after the second pop of a block
        drv(0, 0, 16'h0000, 1);
        drv(0, 0, 16'h0000, 1);
        chk("fl pre inb", int'(b0.in_block), 1);
        chk("fl pre lvl", int'(b0.level), 12);
        drv(1, 0, 16'h0000, 0);
        chk("fl lvl0", int'(b0.level), 0);
        chk("fl lvl1", int'(b1.level), 0);
        chk("fl inb", int'(b0.in_block), 0);
        chk("fl rdy", int'(b0.rd_ready), 0);
        chk("fl cnt0", int'(b0.ovf_cnt), 3);
        chk("fl cnt1", int'(b1.ovf_cnt), 3);
        chk("fl err", int'(b0.rd_err), 1);

        // ovf_cnt saturation (4-bit counter)
        for (int i = 0; i < 30; i++) drv(0, 1, 16'(16'h0100 + i), 0);
        chk("sat lvl", int'(b0.level), 16);
        chk("sat cnt0", int'(b0.ovf_cnt), 15);
        chk("sat cnt1", int'(b1.ovf_cnt), 15);
        drv(0, 1, 16'h0200, 0);
        chk("sat hold", int'(b0.ovf_cnt), 15);

        // reset mid-block
        drv(0, 0, 16'h0000, 1);
        drv(0, 0, 16'h0000, 1);
        chk("rst pre inb", int'(b1.in_block), 1);
        rst = 1'b1;
        drv(0, 0, 16'h0000, 0);
        chk_reset("midrst");
        rst = 1'b0;

        drv(0, 0, 16'h0000, 1);
        chk("empty rd err", int'(b0.rd_err), 1);
        chk("empty rd lvl", int'(b0.level), 0);
        drv(0, 1, 16'h005a, 0);
        chk("post wr dout", int'(b0.dout), 16'h005a);
        chk("post wr lvl", int'(b0.level), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
